cook_cmd_sequencer: RTL and testbench
=====================================

# cook_cmd_sequencer

Command sequencer for the microwave cook cycle. Receives byte strobes from the UART receiver and start pulses from the debounced button, and builds a 4-digit MM:SS entry from keyboard digits. Commits the entered time to the countdown timer and sequences the cook, pause, done and idle phases from the timer's end pulse. Sits between the UART/button front end and the 7-segment timer, LED and VGA masters, and replaces direct wiring of the start/idle levels.

## Interface
- DONE_CYCLES, 100_000_000: cycles the DONE phase is held (1 s at 100 MHz).
- QUICK_SEC, 30: seconds loaded by a start with an empty entry buffer (range 1–59).
- TIMEOUT_CYCLES, 500_000_000: idle cycles before a partial entry is discarded (used only with ENTRY_TIMEOUT_EN).
- sys_clk  in  1  system clock; all logic on the rising edge.
- sys_rst_n  in  1  asynchronous active-low reset.
- rx_byte  in  8  received byte; valid only when rx_valid is high.
- rx_valid  in  1  one-cycle strobe from the UART receiver.
- btn_start  in  1  one-cycle debounced start pulse.
- timer_end  in  1  one-cycle pulse from the countdown timer at 00:00.
- load_minutes  out  6  committed minutes, binary 0–59.
- load_seconds  out  6  committed seconds, binary 0–59.
- load_stb  out  1  one-cycle pulse; the timer samples load_* on this pulse.
- start  out  1  high while cooking.
- idle  out  1  high in IDLE and ENTRY.
- paused  out  1  high in PAUSE.
- done  out  1  high in DONE.

## Operation
- States: IDLE, ENTRY, COOK, PAUSE, DONE. Reset state is IDLE.
- Byte decode (all other bytes ignored):
  - 0x30–0x39: digit.
  - 0x20: start.
  - 0x70 ('p'): pause.
  - 0x63 ('c'): cancel.
- A btn_start pulse is identical to a 0x20 start. A button pulse and a start byte in the same cycle count as one start.
- Digits:
  - In IDLE or ENTRY, a digit shifts into the 4-digit BCD buffer {M1,M0,S1,S0}: S0 receives the new digit, M1 is discarded. IDLE moves to ENTRY.
  - Digits in COOK, PAUSE or DONE are ignored.
- Commit (start in IDLE or ENTRY):
  - Minutes = 10*M1+M0, saturated to 59. Seconds = 10*S1+S0, saturated to 59.
  - If the buffer is all zero, the committed value is 0:QUICK_SEC.
  - load_* are updated, load_stb pulses, the buffer is cleared, and the state goes to COOK.
- COOK:
  - pause → PAUSE.
  - timer_end → DONE.
  - start is ignored.
- PAUSE:
  - start → COOK, with no load_stb (the timer resumes).
  - timer_end is ignored.
- DONE: held for DONE_CYCLES, then IDLE. A start in DONE is ignored.
- Cancel in any state → IDLE. Cancel clears the buffer and resets load_* to 0 (no load_stb). Cancel has priority over every other event in the same cycle.
- Within COOK, timer_end has priority over a pause in the same cycle.

## Timing
- All outputs are registered.
- An event in cycle N is reflected on the state outputs and load_* in cycle N+1. load_stb is high only in N+1.
- Reset values: load_minutes=0, load_seconds=0, load_stb=0, start=0, idle=1, paused=0, done=0. The BCD buffer and all counters reset to 0.
- Asserting reset mid-cook forces IDLE asynchronously.
- DONE counter:
  - Width $clog2(DONE_CYCLES).
  - Counts from 0 on entry to DONE.
  - Exits after exactly DONE_CYCLES cycles with done high.
- Exactly one of start, idle, paused, done is high at any time.

## Configuration
- ENTRY_TIMEOUT_EN defined:
  - In ENTRY, a counter increments each cycle with no rx_valid and reloads to 0 on any accepted byte.
  - At TIMEOUT_CYCLES the buffer clears and the state returns to IDLE. No outputs change except idle, which stays 1.
- ENTRY_TIMEOUT_EN undefined: no timeout counter exists, and ENTRY persists until start or cancel.

## Structure
- Package cook_pkg holds:
  - the state enum;
  - the ASCII constants (KEY_SPACE, KEY_PAUSE, KEY_CANCEL, KEY_DIGIT0/9);
  - the limits MAX_MIN=59 and MAX_SEC=59.
- Sub-module bcd_entry_buf holds the 4-digit shift register, clear, empty flag, and the saturating BCD-to-binary conversion (combinational output).
- The sequencer FSM, DONE counter and optional timeout counter live in cook_cmd_sequencer.

## Test plan
- Entry and commit: bytes '1','2','3','0' then 0x20 → load_minutes=12, load_seconds=30, one load_stb, start=1 one cycle after the space.
- Quick start and button: btn_start from IDLE with an empty buffer → load 0:30, start=1. Then timer_end → done=1 for DONE_CYCLES (set to 16 in the bench), then idle=1.
- Saturation and overflow:
  - '9','9','9','9',space → 59:59.
  - '1','2','3','4','5',space → 23:45.
- Pause and cancel:
  - In COOK, 'p' → paused=1.
  - Then space → start=1 with no load_stb.
  - Then 'c' → idle=1 and load_*=0.
  - 'c' and timer_end in the same cycle → IDLE, not DONE.
- Reset and timeout:
  - Assert sys_rst_n low mid-cook → all outputs at reset values immediately.
  - With ENTRY_TIMEOUT_EN and TIMEOUT_CYCLES=32: '5' followed by 32 silent cycles → buffer empty. A following space loads 0:30.

Source files
------------

// File: rtl/cook_pkg.sv
// cook_pkg: shared state encoding, key codes and limits for the cook command sequencer.
package cook_pkg;
   typedef enum logic [2:0] {ST_IDLE, ST_ENTRY, ST_COOK, ST_PAUSE, ST_DONE} state_e;
   localparam logic [7:0] KEY_SPACE  = 8'h20;
   localparam logic [7:0] KEY_PAUSE  = 8'h70;
   localparam logic [7:0] KEY_CANCEL = 8'h63;
   localparam logic [7:0] KEY_DIGIT0 = 8'h30;
   localparam logic [7:0] KEY_DIGIT9 = 8'h39;
   localparam logic [5:0] MAX_MIN    = 6'd59;
   localparam logic [5:0] MAX_SEC    = 6'd59;
   function automatic logic [5:0] bcd_sat(input logic [3:0] hi, input logic [3:0] lo, input logic [5:0] lim);
      logic [6:0] v;
      v = 7'(hi) * 7'd10 + 7'(lo);
      return (v > 7'(lim)) ? lim : v[5:0];
   endfunction
endpackage

// File: rtl/bcd_entry_buf.sv
// bcd_entry_buf: 4-digit MM:SS BCD shift register with clear, empty flag and saturating binary view.
module bcd_entry_buf
   import cook_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       shift_i,
   input  logic       clr_i,
   input  logic [3:0] digit_i,
   output logic       empty_o,
   output logic [5:0] min_o,
   output logic [5:0] sec_o
);
   logic [15:0] dig_q, dig_d;
   always_comb dig_d = clr_i ? '0 : shift_i ? {dig_q[11:0], digit_i} : dig_q;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) dig_q <= '0;
      else        dig_q <= dig_d;
   assign empty_o = dig_q == '0;
   assign min_o   = bcd_sat(dig_q[15:12], dig_q[11:8], MAX_MIN);
   assign sec_o   = bcd_sat(dig_q[7:4], dig_q[3:0], MAX_SEC);
endmodule

// File: rtl/cook_cmd_sequencer.sv
// cook_cmd_sequencer: keyboard/button command FSM driving the cook timer (IDLE/ENTRY/COOK/PAUSE/DONE).
// Define ENTRY_TIMEOUT_EN to discard a partial entry after TIMEOUT_CYCLES silent cycles.
module cook_cmd_sequencer
   import cook_pkg::*;
#(
   parameter int DONE_CYCLES    = 100_000_000,
   parameter int QUICK_SEC      = 30,
   parameter int TIMEOUT_CYCLES = 500_000_000
) (
   input  logic       sys_clk,
   input  logic       sys_rst_n,
   input  logic [7:0] rx_byte,
   input  logic       rx_valid,
   input  logic       btn_start,
   input  logic       timer_end,
   output logic [5:0] load_minutes,
   output logic [5:0] load_seconds,
   output logic       load_stb,
   output logic       start,
   output logic       idle,
   output logic       paused,
   output logic       done
);
   localparam int DW = $clog2(DONE_CYCLES);
   state_e        state_q, state_d;
   logic [DW-1:0] dcnt_q, dcnt_d;
   logic [5:0]    lmin_q, lmin_d, lsec_q, lsec_d;
   logic          stb_q, stb_d;
   logic          shift, clr, empty, tmo_fire;
   logic [5:0]    emin, esec;
   logic          is_digit, is_start, is_pause, is_cancel;
   assign is_digit  = rx_valid && rx_byte >= KEY_DIGIT0 && rx_byte <= KEY_DIGIT9;
   assign is_start  = btn_start || (rx_valid && rx_byte == KEY_SPACE);
   assign is_pause  = rx_valid && rx_byte == KEY_PAUSE;
   assign is_cancel = rx_valid && rx_byte == KEY_CANCEL;
   bcd_entry_buf u_buf (
      .clk     (sys_clk),
      .rst_n   (sys_rst_n),
      .shift_i (shift),
      .clr_i   (clr),
      .digit_i (rx_byte[3:0]),
      .empty_o (empty),
      .min_o   (emin),
      .sec_o   (esec)
   );
`ifdef ENTRY_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES);
   logic [TW-1:0] tcnt_q, tcnt_d;
   always_comb tcnt_d = (state_q != ST_ENTRY || rx_valid) ? '0 : tcnt_q + 1'b1;
   assign tmo_fire = state_q == ST_ENTRY && !rx_valid && tcnt_q == TW'(TIMEOUT_CYCLES - 1);
   always_ff @(posedge sys_clk or negedge sys_rst_n)
      if (!sys_rst_n) tcnt_q <= '0;
      else            tcnt_q <= tcnt_d;
`else
   // no timeout counter in this build; the term only keeps the parameter referenced
   assign tmo_fire = 1'b0 && (TIMEOUT_CYCLES > 0);
`endif
   always_comb begin
      state_d = state_q;
      dcnt_d  = '0;
      lmin_d  = lmin_q;
      lsec_d  = lsec_q;
      stb_d   = 1'b0;
      shift   = 1'b0;
      clr     = 1'b0;
      if (is_cancel) begin
         state_d = ST_IDLE;
         clr     = 1'b1;
         lmin_d  = '0;
         lsec_d  = '0;
      end else begin
         case (state_q)
            ST_IDLE, ST_ENTRY:
               if (is_start) begin
                  state_d = ST_COOK;
                  clr     = 1'b1;
                  stb_d   = 1'b1;
                  lmin_d  = empty ? '0 : emin;
                  lsec_d  = empty ? 6'(QUICK_SEC) : esec;
               end else if (is_digit) begin
                  state_d = ST_ENTRY;
                  shift   = 1'b1;
               end else if (tmo_fire) begin
                  state_d = ST_IDLE;
                  clr     = 1'b1;
               end
            // a same-cycle timer_end beats pause
            ST_COOK:  state_d = timer_end ? ST_DONE : is_pause ? ST_PAUSE : ST_COOK;
            ST_PAUSE: state_d = is_start ? ST_COOK : ST_PAUSE;
            ST_DONE:
               if (dcnt_q == DW'(DONE_CYCLES - 1)) state_d = ST_IDLE;
               else dcnt_d = dcnt_q + 1'b1;
            default:  state_d = ST_IDLE;
         endcase
      end
   end
   always_ff @(posedge sys_clk or negedge sys_rst_n)
      if (!sys_rst_n) begin
         state_q <= ST_IDLE;
         dcnt_q  <= '0;
         lmin_q  <= '0;
         lsec_q  <= '0;
         stb_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         dcnt_q  <= dcnt_d;
         lmin_q  <= lmin_d;
         lsec_q  <= lsec_d;
         stb_q   <= stb_d;
      end
   assign load_minutes = lmin_q;
   assign load_seconds = lsec_q;
   assign load_stb     = stb_q;
   assign start        = state_q == ST_COOK;
   assign idle         = state_q == ST_IDLE || state_q == ST_ENTRY;
   assign paused       = state_q == ST_PAUSE;
   assign done         = state_q == ST_DONE;
endmodule

// File: tb/tb_cook_cmd_sequencer.sv
// tb_cook_cmd_sequencer: directed plus randomized check of cook_cmd_sequencer against a behavioural model.
module tb_cook_cmd_sequencer;
   localparam int DONE_N = 16;
   localparam int QUICK  = 30;
   localparam int TMO    = 32;
   localparam int P_IDLE = 0, P_ENTRY = 1, P_COOK = 2, P_PAUSE = 3, P_DONE = 4;
   logic       sys_clk = 1'b0;
   logic       sys_rst_n = 1'b1;
   logic [7:0] rx_byte = 8'h00;
   logic       rx_valid = 1'b0, btn_start = 1'b0, timer_end = 1'b0;
   logic [5:0] load_minutes, load_seconds;
   logic       load_stb, start, idle, paused, done;
   int n_tests = 0, n_fail = 0;
   int m_phase, m_entry, m_min, m_sec, m_done_left, m_silent;
   bit m_stb;
   cook_cmd_sequencer #(.DONE_CYCLES(DONE_N), .QUICK_SEC(QUICK), .TIMEOUT_CYCLES(TMO)) dut (
      .sys_clk      (sys_clk),
      .sys_rst_n    (sys_rst_n),
      .rx_byte      (rx_byte),
      .rx_valid     (rx_valid),
      .btn_start    (btn_start),
      .timer_end    (timer_end),
      .load_minutes (load_minutes),
      .load_seconds (load_seconds),
      .load_stb     (load_stb),
      .start        (start),
      .idle         (idle),
      .paused       (paused),
      .done         (done)
   );
   always #5 sys_clk = ~sys_clk;
   initial begin
      #5ms;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask
   function automatic int sat59(input int v);
      return v > 59 ? 59 : v;
   endfunction
   task automatic model_reset();
      m_phase = P_IDLE; m_entry = 0; m_min = 0; m_sec = 0;
      m_stb = 1'b0; m_done_left = 0; m_silent = 0;
   endtask
   // entry is kept as the decimal number typed so far (last four digits)
   task automatic model_step(input bit v, input logic [7:0] b, input bit bt, input bit te);
      bit dig, st, pz, cx;
      dig = v && b >= 8'h30 && b <= 8'h39;
      st  = bt || (v && b == 8'h20);
      pz  = v && b == 8'h70;
      cx  = v && b == 8'h63;
      m_stb = 1'b0;
      if (cx) begin
         m_phase = P_IDLE; m_entry = 0; m_min = 0; m_sec = 0; m_silent = 0;
      end else if (m_phase == P_IDLE || m_phase == P_ENTRY) begin
         if (st) begin
            m_min = m_entry == 0 ? 0 : sat59(m_entry / 100);
            m_sec = m_entry == 0 ? QUICK : sat59(m_entry % 100);
            m_entry = 0; m_stb = 1'b1; m_phase = P_COOK;
         end else if (dig) begin
            m_entry = (m_entry * 10 + (int'(b) - 48)) % 10000;
            m_phase = P_ENTRY; m_silent = 0;
         end
`ifdef ENTRY_TIMEOUT_EN
         else if (m_phase == P_ENTRY) begin
            m_silent = v ? 0 : m_silent + 1;
            if (m_silent == TMO) begin
               m_phase = P_IDLE; m_entry = 0; m_silent = 0;
            end
         end
`endif
      end else if (m_phase == P_COOK) begin
         if (te) begin m_phase = P_DONE; m_done_left = DONE_N; end
         else if (pz) m_phase = P_PAUSE;
      end else if (m_phase == P_PAUSE) begin
         if (st) m_phase = P_COOK;
      end else begin
         m_done_left--;
         if (m_done_left == 0) m_phase = P_IDLE;
      end
   endtask
   task automatic compare_all();
      check("load_minutes", 32'(load_minutes), 32'(m_min));
      check("load_seconds", 32'(load_seconds), 32'(m_sec));
      check("load_stb", 32'(load_stb), 32'(m_stb));
      check("start", 32'(start), 32'(m_phase == P_COOK));
      check("idle", 32'(idle), 32'(m_phase == P_IDLE || m_phase == P_ENTRY));
      check("paused", 32'(paused), 32'(m_phase == P_PAUSE));
      check("done", 32'(done), 32'(m_phase == P_DONE));
      check("onehot", 32'(32'(start) + 32'(idle) + 32'(paused) + 32'(done)), 32'd1);
   endtask
   task automatic step(input bit v, input logic [7:0] b, input bit bt, input bit te);
      rx_valid = v; rx_byte = b; btn_start = bt; timer_end = te;
      model_step(v, b, bt, te);
      @(negedge sys_clk);
      compare_all();
   endtask
   task automatic key(input logic [7:0] b);
      step(1'b1, b, 1'b0, 1'b0);
   endtask
   task automatic quiet(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, 1'b0);
   endtask
   initial begin
      model_reset();
      #1 sys_rst_n = 1'b0;
      repeat (2) @(negedge sys_clk);
      compare_all();
      sys_rst_n = 1'b1;
      // typed entry and commit
      key("1"); key("2"); key("3"); key("0"); key(" ");
      check("commit_min", 32'(load_minutes), 32'd12);
      check("commit_sec", 32'(load_seconds), 32'd30);
      check("commit_stb", 32'(load_stb), 32'd1);
      check("commit_start", 32'(start), 32'd1);
      key("p");
      check("pause", 32'(paused), 32'd1);
      key(" ");
      check("resume_start", 32'(start), 32'd1);
      check("resume_nostb", 32'(load_stb), 32'd0);
      key("c");
      check("cancel_idle", 32'(idle), 32'd1);
      check("cancel_min", 32'(load_minutes), 32'd0);
      // quick start by button then done phase
      step(1'b0, 8'h00, 1'b1, 1'b0);
      check("quick_sec", 32'(load_seconds), 32'd30);
      check("quick_start", 32'(start), 32'd1);
      step(1'b0, 8'h00, 1'b0, 1'b1);
      check("done_enter", 32'(done), 32'd1);
      for (int i = 0; i < DONE_N - 1; i++) begin
         quiet(1);
         check("done_hold", 32'(done), 32'd1);
      end
      quiet(1);
      check("done_exit", 32'(idle), 32'd1);
      // saturation and overflow
      key("9"); key("9"); key("9"); key("9"); key(" ");
      check("sat_min", 32'(load_minutes), 32'd59);
      check("sat_sec", 32'(load_seconds), 32'd59);
      key("c");
      key("1"); key("2"); key("3"); key("4"); key("5"); key(" ");
      check("ovf_min", 32'(load_minutes), 32'd23);
      check("ovf_sec", 32'(load_seconds), 32'd45);
      // cancel beats timer_end
      step(1'b1, "c", 1'b0, 1'b1);
      check("cx_te_idle", 32'(idle), 32'd1);
      check("cx_te_done", 32'(done), 32'd0);
      // asynchronous reset mid-cook
      key(" ");
      #2 sys_rst_n = 1'b0;
      #1;
      check("rst_start", 32'(start), 32'd0);
      check("rst_idle", 32'(idle), 32'd1);
      check("rst_min", 32'(load_minutes), 32'd0);
      check("rst_sec", 32'(load_seconds), 32'd0);
      model_reset();
      @(negedge sys_clk);
      compare_all();
      sys_rst_n = 1'b1;
      // partial entry followed by silence
      key("5");
      quiet(TMO);
      key(" ");
`ifdef ENTRY_TIMEOUT_EN
      check("tmo_sec", 32'(load_seconds), 32'd30);
`else
      check("tmo_sec", 32'(load_seconds), 32'd5);
`endif
      key("c");
      // randomized traffic
      for (int i = 0; i < 4000; i++) begin
         int r;
         logic [7:0] b;
         r = int'($urandom_range(0, 31));
         b = r < 10 ? 8'(48 + r) : r < 14 ? 8'h20 : r < 16 ? 8'h70 : r == 16 ? 8'h63 : 8'($urandom);
         step($urandom_range(0, 99) < 40, b, $urandom_range(0, 99) < 3, $urandom_range(0, 99) < 5);
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
